fetch_seq: RTL and testbench

Instruction-fetch sequencer for the cpu32 core. It drives the PC register's update enable and next value, fetches one instruction word per PC from instruction memory over a request/acknowledge handshake, and presents the fetched word to decode. Branch redirects and traps are applied to the PC with fixed priority. A redirect that arrives while a fetch is outstanding is held until that fetch retires.

---
 rtl/fetch_seq_pkg.sv | 22 ++
 rtl/fetch_next_sel.sv | 34 +++
 rtl/fetch_seq.sv | 110 +++++++++++
 tb/tb_fetch_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared cpu32 fetch definitions: state encodings, instruction width, default vectors.
package fetch_seq_pkg;
  localparam int INSTR_W = 32;

  localparam logic [1:0] FS_INIT = 2'd0;
  localparam logic [1:0] FS_REQ  = 2'd1;
  localparam logic [1:0] FS_HOLD = 2'd2;

  localparam logic [INSTR_W-1:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] TRAP_VEC_DEF  = 32'h0000_0100;

  // Redirect/trap captured while a fetch is outstanding.
  typedef struct packed {
    logic               vld;
    logic               trap;
    logic [INSTR_W-1:0] tgt;
  } pend_t;

  function automatic logic misaligned(input logic [INSTR_W-1:0] a);
    return a[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/fetch_next_sel.sv
// Next-PC priority mux (trap > redirect > pending > pc+4) with target alignment check.
module fetch_next_sel
  import fetch_seq_pkg::*;
#(
  parameter logic [INSTR_W-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic [INSTR_W-1:0] pc,
  input  logic               trap,
  input  logic               redir_valid,
  input  logic [INSTR_W-1:0] redir_target,
  input  pend_t              pend,
  output logic [INSTR_W-1:0] next_pc,
  output logic               fault
);
  logic [INSTR_W-1:0] tgt;

  // A live redirect supersedes a held one; a held trap still wins over both.
  assign tgt = redir_valid ? redir_target : pend.tgt;

  always_comb begin
    next_pc = pc + 32'd4;
    fault   = 1'b0;
    if (trap || (pend.vld && pend.trap)) begin
      next_pc = TRAP_VEC;
    end else if (redir_valid || pend.vld) begin
      if (misaligned(tgt)) begin
        next_pc = TRAP_VEC;
        fault   = 1'b1;
      end else begin
        next_pc = tgt;
      end
    end
  end
endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: drives the external PC register, fetches one word per PC, feeds decode.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [INSTR_W-1:0] TRAP_VEC  = TRAP_VEC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] pc,
  output logic               pc_en,
  output logic [INSTR_W-1:0] pc_next,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redir_valid,
  input  logic [INSTR_W-1:0] redir_target,
  input  logic               trap,
  output logic               fault
);
  logic [1:0]         state, state_nxt;
  pend_t              pend, pend_nxt;
  logic [INSTR_W-1:0] sel_pc;
  logic               sel_fault;
  logic               redir_now, has_redir, take_word;
  logic               pc_en_raw, req_raw, fault_raw;

  fetch_next_sel #(.TRAP_VEC(TRAP_VEC)) u_sel (
    .pc           (pc),
    .trap         (trap),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .pend         (pend),
    .next_pc      (sel_pc),
    .fault        (sel_fault)
  );

  assign redir_now = trap | redir_valid;
  assign has_redir = pend.vld | redir_now;
  assign take_word = (state == FS_REQ) && imem_ack && !has_redir;
  assign imem_addr = pc;

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    pc_en_raw = 1'b0;
    pc_next   = sel_pc;
    fault_raw = 1'b0;
    req_raw   = 1'b0;
    case (state)
      FS_INIT: begin
        pc_en_raw = 1'b1;
        pc_next   = RESET_VEC;
        pend_nxt  = '0;
        state_nxt = FS_REQ;
      end
      FS_REQ: begin
        req_raw = 1'b1;
        if (imem_ack) begin
          if (has_redir) begin
            // Word is stale: drop it and refetch from the redirect target.
            pc_en_raw = 1'b1;
            fault_raw = sel_fault;
            pend_nxt  = '0;
          end else begin
            state_nxt = FS_HOLD;
          end
        end else if (trap) begin
          pend_nxt = '{vld: 1'b1, trap: 1'b1, tgt: TRAP_VEC};
        end else if (redir_valid && !(pend.vld && pend.trap)) begin
          pend_nxt = '{vld: 1'b1, trap: 1'b0, tgt: redir_target};
        end
      end
      FS_HOLD: begin
        if (ir_ready || redir_now) begin
          pc_en_raw = 1'b1;
          fault_raw = sel_fault;
          state_nxt = FS_REQ;
        end
      end
      default: state_nxt = FS_INIT;
    endcase
  end

  assign pc_en    = pc_en_raw & ~rst;
  assign imem_req = req_raw & ~rst;
  assign fault    = fault_raw & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FS_INIT;
      pend     <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      if (take_word) begin
        ir       <= imem_rdata;
        ir_valid <= 1'b1;
      end else if (state == FS_HOLD && pc_en_raw) begin
        ir_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with an external PC register model and IR scoreboard.
module tb_fetch_seq;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc = 32'h0;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        trap;
  logic        fault;
  logic        pc_ld = 1'b0;
  logic [31:0] pc_ld_val = 32'h0;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_ir_q[$];
  logic [31:0] exp_addr_q[$];

  fetch_seq dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redir_valid(redir_valid), .redir_target(redir_target), .trap(trap),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // External PC register; the bench can also load it directly.
  always @(posedge clk) begin
    if (pc_ld)      pc <= pc_ld_val;
    else if (pc_en) pc <= pc_next;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ir(input string tag);
    if (exp_ir_q.size() == 0) chk({tag, "_q_empty"}, 32'd1, 32'd0);
    else begin
      chk({tag, "_vld"}, {31'd0, ir_valid}, 32'd1);
      chk(tag, ir, exp_ir_q.pop_front());
    end
  endtask

  // In REQ: ack now with data; expect the word to land in IR.
  task automatic fetch_now(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, addr);
    imem_ack = 1'b1; imem_rdata = data;
    exp_ir_q.push_back(data);
    tick();
    imem_ack = 1'b0;
    chk_ir({tag, "_ir"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b0;
    redir_valid = 1'b0; redir_target = '0; trap = 1'b0;

    // Reset start
    tick();
    chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_ir_vld", {31'd0, ir_valid}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("init_pc_en", {31'd0, pc_en}, 32'd1);
    chk("init_pc_next", pc_next, 32'd0);
    chk("init_no_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("first_pc", pc, 32'd0);
    fetch_now("first", 32'd0, 32'h1111_0001);

    // Sequential stream, one IR per 2 cycles
    exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8); exp_addr_q.push_back(32'hC);
    ir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      fetch_now("seq", exp_addr_q.pop_front(), 32'hA5A5_0000 + i);
    end
    ir_ready = 1'b0;

    // Stall 5 cycles
    for (int i = 0; i < 5; i++) begin
      #1; chk("stall_pc_en", {31'd0, pc_en}, 32'd0);
      tick();
    end
    chk("stall_ir", ir, 32'hA5A5_0002);
    chk("stall_pc", pc, 32'hC);

    // Redirect during a 3-wait fetch
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    chk("rw_addr0", imem_addr, 32'h10);
    tick();
    redir_valid = 1'b1; redir_target = 32'h0000_2000;
    #1; chk("rw_no_apply", {31'd0, pc_en}, 32'd0);
    tick();
    redir_valid = 1'b0;
    chk("rw_addr_hold", imem_addr, 32'h10);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0000;
    #1;
    chk("rw_pc_en", {31'd0, pc_en}, 32'd1);
    chk("rw_pc_next", pc_next, 32'h2000);
    tick();
    imem_ack = 1'b0;
    chk("rw_dropped", {31'd0, ir_valid}, 32'd0);
    fetch_now("rw_new", 32'h2000, 32'h2222_0000);

    // Trap and redirect in the same HOLD cycle
    trap = 1'b1; redir_valid = 1'b1; redir_target = 32'h3000;
    #1;
    chk("pri_pc_next", pc_next, TV);
    tick();
    trap = 1'b0; redir_valid = 1'b0;
    chk("pri_ir_drop", {31'd0, ir_valid}, 32'd0);
    fetch_now("pri_fetch", TV, 32'h3333_0000);

    // Redirect after a pending trap in REQ
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    trap = 1'b1;
    tick();
    trap = 1'b0; redir_valid = 1'b1; redir_target = 32'h4000;
    tick();
    redir_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
    #1;
    chk("ptrap_pc_next", pc_next, TV);
    tick();
    imem_ack = 1'b0;
    chk("ptrap_ir_vld", {31'd0, ir_valid}, 32'd0);
    fetch_now("ptrap_fetch", TV, 32'h4444_0000);

    // Misaligned redirect in HOLD
    redir_valid = 1'b1; redir_target = 32'h0000_2002;
    #1;
    chk("mis_pc_next", pc_next, TV);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    tick();
    redir_valid = 1'b0;
    chk("mis_fault_end", {31'd0, fault}, 32'd0);
    fetch_now("mis_fetch", TV, 32'h5555_0000);

    // PC wrap
    pc_ld = 1'b1; pc_ld_val = 32'hFFFF_FFFC;
    tick();
    pc_ld = 1'b0; ir_ready = 1'b1;
    #1;
    chk("wrap_pc_next", pc_next, 32'h0);
    tick();
    ir_ready = 1'b0;
    fetch_now("wrap_fetch", 32'h0, 32'h6666_0000);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    chk("prerst_addr", imem_addr, 32'h4);

    // Reset mid-REQ, late ACK in INIT ignored
    rst = 1'b1;
    #1;
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD1_0000;
    #1;
    chk("mrst_init_pc_next", pc_next, 32'h0);
    tick();
    imem_ack = 1'b0;
    chk("mrst_late_ack", {31'd0, ir_valid}, 32'd0);
    chk("mrst_pc", pc, 32'h0);
    fetch_now("mrst_fetch", 32'h0, 32'h7777_0000);

    chk("ir_q_drained", exp_ir_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
